rv32i_alu: RTL and testbench
============================

// Module: rv32i_alu
// PURPOSE
//  Execute-stage ALU of the multicycle RV32I core. Computes all RV32I integer ops
//  combinationally and latches the result in AluOut_reg during EXECUTE.
//  Resolves branch conditions and produces the next-PC value pc_up_reg during BRANCH.
//  Sits between the register-file/immediate operand muxes and the PC/writeback logic.
// PARAMETERS
//  XLEN       32     datapath width (only 32 supported)
//  STG_EXEC   5'd2   current_stage code for ALU execute
//  STG_BRANCH 5'd16  current_stage code for branch/jump PC resolution
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  opcode_reg     in   7   instruction opcode [6:0]
//  AluControl_reg in   4   operation select (see BEHAVIOUR)
//  SrcA_reg       in   32  operand A
//  SrcB_reg       in   32  operand B
//  PCSrc_reg      in   1   branch/jump instruction qualifier from control
//  current_stage  in   5   multicycle stage code
//  AluResult_reg  out  32  combinational ALU result
//  AluOut_reg     out  32  registered ALU result
//  Cond_Chk_reg   out  1   registered branch condition
//  pc_up_reg      out  32  registered PC-update value
// BEHAVIOUR
//  - Reset (reset=0, async): AluOut_reg, Cond_Chk_reg and pc_up_reg = 0.
//    AluResult_reg stays combinational.
//  - AluControl encoding / AluResult:
//    0000 ADD A+B; 0001 SUB A-B; 0010 SLL A<<B[4:0]; 0011 SLT signed A<B ? 1:0;
//    0100 SLTU unsigned A<B ? 1:0; 0101 XOR; 0110 SRL logical >>B[4:0];
//    0111 SRA arithmetic >>>B[4:0]; 1110 OR; 1111 AND.
//    1000 BEQ, 1001 BNE, 1010 BLT, 1011 BGE, 1100 BLTU, 1101 BGEU: AluResult=A-B.
//  - All arithmetic mod 2^32; no overflow flags; shift amount uses B[4:0] only.
//  - cond (combinational): evaluated only for codes 1000-1101; 0 for all other codes.
//    BLT/BGE use signed compare; BLTU/BGEU use unsigned compare.
//  - Rising edge, current_stage==STG_EXEC: AluOut_reg <= AluResult. Otherwise AluOut_reg holds.
//  - Rising edge, current_stage==STG_BRANCH:
//    - opcode 1100011 (branch): Cond_Chk_reg <= cond.
//      If PCSrc_reg && cond: pc_up_reg <= AluOut_reg (branch target computed
//      earlier as PC+imm). Otherwise pc_up_reg holds.
//    - opcode 1101111 (JAL) with PCSrc_reg: Cond_Chk_reg <= 1; pc_up_reg <= AluOut_reg.
//    - opcode 1100111 (JALR) with PCSrc_reg: Cond_Chk_reg <= 1;
//      pc_up_reg <= AluOut_reg & ~32'h1.
//    - Any other opcode: Cond_Chk_reg <= 0; pc_up_reg holds.
//  - All other stage codes: AluOut_reg, Cond_Chk_reg and pc_up_reg hold.
//  - Latency: AluResult 0 cycles; AluOut_reg/Cond_Chk_reg/pc_up_reg 1 edge.
//  - Reset mid-operation: registers clear immediately; the stage sequence restarts under control.
// STRUCTURE
//  - Shared package rv32i_pkg: opcode constants (OP_R=0110011, OP_B=1100011,
//    OP_JAL=1101111, OP_JALR=1100111), AluControl code constants, stage codes.
//  - One combinational sub-module rv32i_alu_comb (A, B, ctrl -> result, cond).
//    The top level holds the three registers and the stage/opcode decode.
// TESTING
//  - Reset: reset=0 -> AluOut_reg=0, Cond_Chk_reg=0, pc_up_reg=0.
//  - ADD: op=0110011, ctrl=0000, A=0x1111, B=0x1010, stage=2 -> AluResult=0x2121;
//    AluOut_reg=0x2121 after edge.
//  - BEQ taken (follows ADD): op=1100011, ctrl=1000, A=B=0x1111, PCSrc=1, stage=16
//    -> AluResult=0, Cond_Chk_reg=1, pc_up_reg=0x2121, AluOut_reg holds 0x2121.
//  - BLT vs BLTU: A=0xFFFFFFFF, B=1 -> BLT cond=1; BLTU cond=0.
//    BNE with A=B -> Cond_Chk_reg=0, pc_up_reg unchanged.
//  - Shifts/SLT: SRA 0x80000000>>>4 = 0xF8000000; SRL = 0x08000000;
//    SLL with B=0x21 shifts by 1; SLT(-1,1)=1; SLTU(-1,1)=0.
//  - JALR: AluOut_reg=0x1235, stage=16, PCSrc=1 -> pc_up_reg=0x1234, Cond_Chk_reg=1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I execute stage: opcodes, ALU control codes, stage codes.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [4:0] STG_EXEC   = 5'd2;
    localparam logic [4:0] STG_BRANCH = 5'd16;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_BEQ  = 4'b1000,
        ALU_BNE  = 4'b1001,
        ALU_BLT  = 4'b1010,
        ALU_BGE  = 4'b1011,
        ALU_BLTU = 4'b1100,
        ALU_BGEU = 4'b1101,
        ALU_OR   = 4'b1110,
        ALU_AND  = 4'b1111
    } alu_ctrl_e;

endpackage

// File: rtl/rv32i_alu_comb.sv
// Combinational RV32I ALU: result and branch condition from operands and control code.
// Latency 0; no flow control.
module rv32i_alu_comb
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_ctrl,
    output logic [XLEN-1:0] o_result,
    output logic            o_cond
);

    logic [4:0] w_shamt;
    logic       w_lt_s;
    logic       w_lt_u;
    logic       w_eq;

    assign w_shamt = i_b[4:0];
    assign w_lt_s  = $signed(i_a) < $signed(i_b);
    assign w_lt_u  = i_a < i_b;
    assign w_eq    = i_a == i_b;

    always_comb begin
        o_result = '0;
        case (alu_ctrl_e'(i_ctrl))
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            default:  o_result = i_a - i_b;
        endcase
    end

    // Only the six branch codes produce a condition; everything else reads as not-taken.
    always_comb begin
        o_cond = 1'b0;
        case (alu_ctrl_e'(i_ctrl))
            ALU_BEQ:  o_cond = w_eq;
            ALU_BNE:  o_cond = !w_eq;
            ALU_BLT:  o_cond = w_lt_s;
            ALU_BGE:  o_cond = !w_lt_s;
            ALU_BLTU: o_cond = w_lt_u;
            ALU_BGEU: o_cond = !w_lt_u;
            default:  o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_alu.sv
// Execute-stage ALU: latches the ALU result in EXECUTE and resolves branch/jump PC in BRANCH.
// Latency: AluResult_reg 0 cycles, registered outputs 1 edge; no backpressure, stage-driven.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      opcode_reg,
    input  logic [3:0]      AluControl_reg,
    input  logic [XLEN-1:0] SrcA_reg,
    input  logic [XLEN-1:0] SrcB_reg,
    input  logic            PCSrc_reg,
    input  logic [4:0]      current_stage,
    output logic [XLEN-1:0] AluResult_reg,
    output logic [XLEN-1:0] AluOut_reg,
    output logic            Cond_Chk_reg,
    output logic [XLEN-1:0] pc_up_reg
);

    logic [XLEN-1:0] w_result;
    logic            w_cond;
    logic [XLEN-1:0] r_alu_out;
    logic            r_cond_chk;
    logic [XLEN-1:0] r_pc_up;

    rv32i_alu_comb u_comb (
        .i_a      (SrcA_reg),
        .i_b      (SrcB_reg),
        .i_ctrl   (AluControl_reg),
        .o_result (w_result),
        .o_cond   (w_cond)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_out <= '0;
        end else if (current_stage == STG_EXEC) begin
            r_alu_out <= w_result;
        end
    end

    // The jump/branch target was computed into r_alu_out during an earlier EXECUTE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cond_chk <= 1'b0;
            r_pc_up    <= '0;
        end else if (current_stage == STG_BRANCH) begin
            if (opcode_reg == OP_B) begin
                r_cond_chk <= w_cond;
                if (PCSrc_reg && w_cond) begin
                    r_pc_up <= r_alu_out;
                end
            end else if (opcode_reg == OP_JAL && PCSrc_reg) begin
                r_cond_chk <= 1'b1;
                r_pc_up    <= r_alu_out;
            end else if (opcode_reg == OP_JALR && PCSrc_reg) begin
                r_cond_chk <= 1'b1;
                r_pc_up    <= r_alu_out & ~32'h1;
            end else begin
                r_cond_chk <= 1'b0;
            end
        end
    end

    assign AluResult_reg = w_result;
    assign AluOut_reg    = r_alu_out;
    assign Cond_Chk_reg  = r_cond_chk;
    assign pc_up_reg     = r_pc_up;

endmodule

// File: tb/tb_rv32i_alu.sv
// Randomized self-checking bench for rv32i_alu against a behavioural ALU/PC model.
module tb_rv32i_alu;
    import rv32i_pkg::*;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode_reg;
    logic [3:0]  AluControl_reg;
    logic [31:0] SrcA_reg;
    logic [31:0] SrcB_reg;
    logic        PCSrc_reg;
    logic [4:0]  current_stage;
    logic [31:0] AluResult_reg;
    logic [31:0] AluOut_reg;
    logic        Cond_Chk_reg;
    logic [31:0] pc_up_reg;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_alu_out;
    logic        m_cond_chk;
    logic [31:0] m_pc_up;

    rv32i_alu dut (
        .clk            (clk),
        .reset          (reset),
        .opcode_reg     (opcode_reg),
        .AluControl_reg (AluControl_reg),
        .SrcA_reg       (SrcA_reg),
        .SrcB_reg       (SrcB_reg),
        .PCSrc_reg      (PCSrc_reg),
        .current_stage  (current_stage),
        .AluResult_reg  (AluResult_reg),
        .AluOut_reg     (AluOut_reg),
        .Cond_Chk_reg   (Cond_Chk_reg),
        .pc_up_reg      (pc_up_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        case (c)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return 32'(64'(a) * (64'd1 << sh));
            4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return 32'(64'(a) / (64'd1 << sh));
            4'd7:  return (sa >= 0) ? 32'(sa / (64'sd1 <<< sh))
                                    : 32'(-((-sa + (64'sd1 <<< sh) - 1) / (64'sd1 <<< sh)));
            4'd14: return a | b;
            4'd15: return a & b;
            default: return a - b;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [3:0] c, input logic [31:0] a,
                                      input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            4'd8:  return a == b;
            4'd9:  return a != b;
            4'd10: return sa < sb;
            4'd11: return sa >= sb;
            4'd12: return a < b;
            4'd13: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Apply one operation for a cycle: check the combinational result, clock, then check registers.
    task automatic apply(input logic [6:0] op, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic pcs, input logic [4:0] stg);
        logic [31:0] exp_res;
        logic        exp_cond;
        opcode_reg     = op;
        AluControl_reg = c;
        SrcA_reg       = a;
        SrcB_reg       = b;
        PCSrc_reg      = pcs;
        current_stage  = stg;
        exp_res  = ref_result(c, a, b);
        exp_cond = ref_cond(c, a, b);
        #2;
        chk("alu_result", AluResult_reg, exp_res);
        @(posedge clk);
        #1;
        if (stg == 5'd2) begin
            m_alu_out = exp_res;
        end else if (stg == 5'd16) begin
            if (op == 7'b1100011) begin
                m_cond_chk = exp_cond;
                if (pcs && exp_cond) m_pc_up = m_alu_out;
            end else if (op == 7'b1101111 && pcs) begin
                m_cond_chk = 1'b1;
                m_pc_up    = m_alu_out;
            end else if (op == 7'b1100111 && pcs) begin
                m_cond_chk = 1'b1;
                m_pc_up    = {m_alu_out[31:1], 1'b0};
            end else begin
                m_cond_chk = 1'b0;
            end
        end
        chk("alu_out", AluOut_reg, m_alu_out);
        chk("cond_chk", {31'd0, Cond_Chk_reg}, {31'd0, m_cond_chk});
        chk("pc_up", pc_up_reg, m_pc_up);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] specials [6];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000;
        specials[3] = 32'h7FFF_FFFF;
        specials[4] = 32'h0000_0001;
        specials[5] = 32'h0000_001F;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [6:0]  ops [5];
        logic [4:0]  stgs [4];
        logic [6:0]  op;
        logic [31:0] a, b;
        logic        pcs;

        ops[0] = 7'b0110011; ops[1] = 7'b1100011; ops[2] = 7'b1101111;
        ops[3] = 7'b1100111; ops[4] = 7'b0010011;
        stgs[0] = 5'd2; stgs[1] = 5'd16; stgs[2] = 5'd0; stgs[3] = 5'd4;

        reset = 1'b0;
        opcode_reg = '0; AluControl_reg = '0; SrcA_reg = '0; SrcB_reg = '0;
        PCSrc_reg = 1'b0; current_stage = 5'd2;
        m_alu_out = '0; m_cond_chk = 1'b0; m_pc_up = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_out", AluOut_reg, 32'h0);
        chk("rst_cond", {31'd0, Cond_Chk_reg}, 32'h0);
        chk("rst_pc_up", pc_up_reg, 32'h0);
        reset = 1'b1;

        apply(7'b0110011, 4'b0000, 32'h1111, 32'h1010, 1'b0, 5'd2);
        chk("add_alu_out", AluOut_reg, 32'h2121);
        apply(7'b1100011, 4'b1000, 32'h1111, 32'h1111, 1'b1, 5'd16);
        chk("beq_pc_up", pc_up_reg, 32'h2121);
        chk("beq_cond", {31'd0, Cond_Chk_reg}, 32'h1);
        chk("beq_alu_hold", AluOut_reg, 32'h2121);

        apply(7'b1100011, 4'b1010, 32'hFFFF_FFFF, 32'h1, 1'b0, 5'd16);
        chk("blt_cond", {31'd0, Cond_Chk_reg}, 32'h1);
        apply(7'b1100011, 4'b1100, 32'hFFFF_FFFF, 32'h1, 1'b0, 5'd16);
        chk("bltu_cond", {31'd0, Cond_Chk_reg}, 32'h0);
        apply(7'b1100011, 4'b1001, 32'h55, 32'h55, 1'b1, 5'd16);
        chk("bne_cond", {31'd0, Cond_Chk_reg}, 32'h0);
        chk("bne_pc_hold", pc_up_reg, 32'h2121);

        apply(7'b0110011, 4'b0111, 32'h8000_0000, 32'd4, 1'b0, 5'd2);
        chk("sra", AluOut_reg, 32'hF800_0000);
        apply(7'b0110011, 4'b0110, 32'h8000_0000, 32'd4, 1'b0, 5'd2);
        chk("srl", AluOut_reg, 32'h0800_0000);
        apply(7'b0110011, 4'b0010, 32'h1, 32'h21, 1'b0, 5'd2);
        chk("sll_mask", AluOut_reg, 32'h2);
        apply(7'b0110011, 4'b0011, 32'hFFFF_FFFF, 32'h1, 1'b0, 5'd2);
        chk("slt", AluOut_reg, 32'h1);
        apply(7'b0110011, 4'b0100, 32'hFFFF_FFFF, 32'h1, 1'b0, 5'd2);
        chk("sltu", AluOut_reg, 32'h0);

        apply(7'b0110011, 4'b0000, 32'h1235, 32'h0, 1'b0, 5'd2);
        apply(7'b1100111, 4'b0000, 32'h0, 32'h0, 1'b1, 5'd16);
        chk("jalr_pc_up", pc_up_reg, 32'h1234);
        chk("jalr_cond", {31'd0, Cond_Chk_reg}, 32'h1);

        for (int i = 0; i < 400; i++) begin
            op  = ops[$urandom_range(0, 4)];
            a   = rand_operand();
            b   = ($urandom_range(0, 4) == 0) ? a : rand_operand();
            pcs = (op == 7'b1101111 || op == 7'b1100111) ? 1'b1 : 1'($urandom_range(0, 1));
            apply(op, 4'($urandom_range(0, 15)), a, b, pcs, stgs[$urandom_range(0, 3)]);
        end

        apply(7'b0110011, 4'b0000, 32'hABCD, 32'h1, 1'b0, 5'd2);
        apply(7'b1101111, 4'b0000, 32'h0, 32'h0, 1'b1, 5'd16);
        chk("jal_pc_up", pc_up_reg, 32'hABCE);
        #2;
        reset = 1'b0;
        #1;
        m_alu_out = '0; m_cond_chk = 1'b0; m_pc_up = '0;
        chk("midrst_alu_out", AluOut_reg, 32'h0);
        chk("midrst_cond", {31'd0, Cond_Chk_reg}, 32'h0);
        chk("midrst_pc_up", pc_up_reg, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply(7'b0110011, 4'b0001, 32'h10, 32'h20, 1'b0, 5'd2);
        chk("post_rst_sub", AluOut_reg, 32'hFFFF_FFF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
